fib_index: RTL

FIB_INDEX -- requirements
Module: fib_index

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_index.sv | 95 +++++++++
 2 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths, limits and state type for the Fibonacci index search
package fib_pkg;

    localparam int FIB_DW      = 16;
    localparam int FIB_IW      = 17;
    localparam int FIB_MAX_IDX = 24;
    localparam int FIB_XW      = $clog2(FIB_MAX_IDX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_index.sv
// rtl/fib_index.sv - finds the largest n with F(n) <= din by walking the Fibonacci sequence
module fib_index
    import fib_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [FIB_DW-1:0] din,
    input  logic              start,
    output logic [FIB_DW-1:0] dout,
    output logic              exact,
    output logic              busy,
    output logic              done
);

    fib_state_e        state_q, state_d;
    logic [FIB_DW-1:0] target_q, target_d;
    logic [FIB_IW-1:0] a_q, a_d;
    logic [FIB_IW-1:0] b_q, b_d;
    logic [FIB_XW-1:0] idx_q, idx_d;
    logic [FIB_DW-1:0] dout_q, dout_d;
    logic              exact_q, exact_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [FIB_IW-1:0] target_ext;

    assign target_ext = FIB_IW'(target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        dout_d   = dout_q;
        exact_d  = exact_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEARCH;
                    target_d = din;
                    a_d      = '0;
                    b_d      = FIB_IW'(1);
                    idx_d    = '0;
                end
            end
            SEARCH: begin
                // a = F(idx), b = F(idx+1); stop once the next term overshoots
                if (b_q > target_ext) begin
                    dout_d  = FIB_DW'(idx_q);
                    exact_d = (a_q == target_ext);
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    a_d   = b_q;
                    b_d   = a_q + b_q;
                    idx_d = idx_q + FIB_XW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            dout_q   <= '0;
            exact_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            exact_q  <= exact_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout  = dout_q;
    assign exact = exact_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
